// File: rtl/apb_regfile_slave.sv
// APB completer serving a bank of 32-bit registers behind the AHB-to-APB bridge.
// Register 0 is a read-only ID word. Every access phase is stretched by a
// fixed number of wait states. Misaligned, out-of-window and ID-write
// accesses complete with an error response.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | no transfer in progress, waiting for a setup cycle
// S_ACCESS | access phase, counting down wait states
module apb_regfile_slave #(
   parameter int          NREGS       = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [5:0]  r_idx;
   logic        r_write;
   logic        r_err;
   logic [31:0] r_wdata;
   logic [31:0] r_regs [1:NREGS-1];

   logic [31:0] w_offset;
   logic        w_misaligned;
   logic        w_out_of_window;
   logic        w_id_write;
   logic        w_err;
   logic        w_setup;
   logic        w_wr_en;
   logic [31:0] w_rdata;

   // Decode the setup-phase address; an underflowing subtraction is caught
   // by the explicit lower-bound compare.
   always_comb begin
      w_offset        = paddr - BASE_ADDR;
      w_misaligned    = (paddr[1:0] != 2'b00);
      w_out_of_window = (paddr < BASE_ADDR) || (w_offset >= 32'(4 * NREGS));
      w_id_write      = pwrite && !w_out_of_window && (w_offset[31:2] == 30'd0);
      w_err           = w_misaligned || w_out_of_window || w_id_write;
      w_setup         = psel && !penable;
   end

   // Transfer sequencing: latch the request at setup, count wait states,
   // complete or abort in the access phase.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_state <= S_ACCESS;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_idx   <= w_offset[7:2];
                  r_write <= pwrite;
                  r_err   <= w_err;
                  r_wdata <= pwdata;
               end
            end
            S_ACCESS: begin
               if (!psel) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else if (penable) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign pready  = (r_state == S_ACCESS) && (r_cnt == 4'd0) && psel && penable;
   assign pslverr = pready && r_err;
   assign w_wr_en = pready && r_write && !r_err;

   // Register bank update; index 0 has no storage, it is the ID constant.
   always_ff @(posedge hclk) begin
      for (int i = 1; i < NREGS; i++) begin
         if (hreset) begin
            r_regs[i] <= '0;
         end else if (w_wr_en && (r_idx == 6'(i))) begin
            r_regs[i] <= r_wdata;
         end
      end
   end

   // Read mux over the latched index; out-of-range indices never reach here
   // without the error flag set, which gates the data to zero.
   always_comb begin
      w_rdata = ID_VALUE;
      for (int i = 1; i < NREGS; i++) begin
         if (r_idx == 6'(i)) begin
            w_rdata = r_regs[i];
         end
      end
   end

   assign prdata = (pready && !r_write && !r_err) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one instance with no wait states and
// one with three, each with its own select line on a shared APB bus.
module tb_apb_regfile_slave;

   localparam logic [31:0] ID = 32'hA5B0_0001;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        psel0, psel3;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3;
   logic        pslverr0, pslverr3;

   int n_asserts = 0;
   int n_fails   = 0;

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] rdata;
      int          ws;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] m0 [16];
   logic [31:0] m3 [16];

   apb_regfile_slave #(.NREGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
      .hclk    (hclk),
      .hreset  (hreset),
      .psel    (psel0),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata0),
      .pready  (pready0),
      .pslverr (pslverr0)
   );

   apb_regfile_slave #(.NREGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ID_VALUE(ID)) dut3 (
      .hclk    (hclk),
      .hreset  (hreset),
      .psel    (psel3),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata3),
      .pready  (pready3),
      .pslverr (pslverr3)
   );

   always #5 hclk = ~hclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m0[i] = 32'd0;
         m3[i] = 32'd0;
      end
      m0[0] = ID;
      m3[0] = ID;
   endtask

   function automatic logic calc_err(input logic wr, input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr >= 32'h40) || (wr && addr < 32'h4);
   endfunction

   function automatic logic [31:0] model_rd(input int d, input logic [3:0] i);
      return (d == 0) ? m0[i] : m3[i];
   endfunction

   task automatic set_psel(input int d, input logic v);
      if (d == 0) psel0 = v;
      else        psel3 = v;
   endtask

   task automatic sample(input int d, output logic rdy, output logic err, output logic [31:0] rd);
      rdy = (d == 0) ? pready0  : pready3;
      err = (d == 0) ? pslverr0 : pslverr3;
      rd  = (d == 0) ? prdata0  : prdata3;
   endtask

   task automatic check_quiet(input int d, input string tag);
      logic rdy, err;
      logic [31:0] rd;
      sample(d, rdy, err, rd);
      check({tag, "_pready"},  {31'd0, rdy}, 32'd0);
      check({tag, "_pslverr"}, {31'd0, err}, 32'd0);
      check({tag, "_prdata"},  rd, 32'd0);
   endtask

   // One complete transfer; starts #1 after a rising edge and leaves the bus
   // idle #1 after the completing edge, so consecutive calls are back-to-back.
   task automatic apb(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
      exp_t        e, x;
      logic        done, rdy, err;
      logic [31:0] rd;
      int          waits;
      e.tag   = $sformatf("d%0d_%s_%h", d, wr ? "wr" : "rd", addr);
      e.err   = calc_err(wr, addr);
      e.rdata = (wr || e.err) ? 32'd0 : model_rd(d, addr[5:2]);
      e.ws    = (d == 0) ? 0 : 3;
      sb.push_back(e);
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      penable = 1'b0;
      set_psel(d, 1'b1);
      @(posedge hclk); #1;
      penable = 1'b1;
      done  = 1'b0;
      waits = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge hclk);
         sample(d, rdy, err, rd);
         if (rdy) begin
            x = sb.pop_front();
            check({x.tag, "_pslverr"}, {31'd0, err}, {31'd0, x.err});
            check({x.tag, "_prdata"}, rd, x.rdata);
            check({x.tag, "_waits"}, 32'(waits), 32'(x.ws));
            if (wr && !x.err) begin
               if (d == 0) m0[addr[5:2]] = data;
               else        m3[addr[5:2]] = data;
            end
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge hclk); #1;
      end
      set_psel(d, 1'b0);
      penable = 1'b0;
      check({e.tag, "_completed"}, {31'd0, done}, 32'd1);
      if (!done) x = sb.pop_front();
   endtask

   initial begin
      hreset  = 1'b1;
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 32'd0;
      pwdata  = 32'd0;
      model_reset();
      repeat (3) @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      check_quiet(0, "reset_d0");
      check_quiet(3, "reset_d3");
      @(posedge hclk); #1;

      // zero-wait instance: ID, plain read/write, window edge, error cases
      apb(0, 1'b0, 32'h00, 32'h0);
      apb(0, 1'b0, 32'h04, 32'h0);
      apb(0, 1'b1, 32'h20, 32'hDEAD_BEEF);
      apb(0, 1'b0, 32'h20, 32'h0);
      apb(0, 1'b1, 32'h3C, 32'h0F0F_1234);
      apb(0, 1'b0, 32'h3C, 32'h0);
      apb(0, 1'b1, 32'h40, 32'h1111_2222);
      apb(0, 1'b0, 32'h40, 32'h0);
      apb(0, 1'b1, 32'h00, 32'h5555_AAAA);
      apb(0, 1'b0, 32'h00, 32'h0);
      apb(0, 1'b1, 32'h22, 32'h7777_7777);
      apb(0, 1'b0, 32'h20, 32'h0);
      apb(0, 1'b0, 32'hFFFF_FFFC, 32'h0);

      // access phase without a setup phase is ignored
      psel0   = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'h9999_9999;
      for (int k = 0; k < 3; k++) begin
         @(negedge hclk);
         check_quiet(0, $sformatf("noseup_%0d", k));
      end
      @(posedge hclk); #1;
      psel0   = 1'b0;
      penable = 1'b0;
      apb(0, 1'b0, 32'h10, 32'h0);

      // three-wait instance
      apb(3, 1'b1, 32'h20, 32'h0BAD_F00D);
      apb(3, 1'b0, 32'h20, 32'h0);
      apb(3, 1'b1, 32'h24, 32'h1234_5678);
      apb(3, 1'b0, 32'h24, 32'h0);
      apb(3, 1'b1, 32'h44, 32'h1);

      // abort a write mid-wait by dropping select
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h28;
      pwdata  = 32'hCAFE_0000;
      @(posedge hclk); #1;
      penable = 1'b1;
      @(negedge hclk);
      check_quiet(3, "abort_wait");
      @(posedge hclk); #1;
      psel3   = 1'b0;
      penable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge hclk);
         check_quiet(3, $sformatf("abort_after_%0d", k));
         @(posedge hclk); #1;
      end
      apb(3, 1'b0, 32'h28, 32'h0);

      // reset during the access phase of a write
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h2C;
      pwdata  = 32'h1357_9BDF;
      @(posedge hclk); #1;
      penable = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b1;
      @(posedge hclk); #1;
      @(negedge hclk);
      check_quiet(3, "midreset");
      @(posedge hclk); #1;
      hreset  = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      model_reset();
      @(posedge hclk); #1;
      apb(3, 1'b0, 32'h2C, 32'h0);
      apb(3, 1'b0, 32'h24, 32'h0);
      apb(3, 1'b0, 32'h00, 32'h0);
      apb(3, 1'b1, 32'h30, 32'h2468_ACE0);
      apb(3, 1'b0, 32'h30, 32'h0);
      apb(0, 1'b0, 32'h20, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
